// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state encodings and widths for the pipeline control slice.
package cpu_pkg;
    localparam int REG_W      = 4;
    localparam int WB_LAT_DEF = 2;
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2,
        STEP   = 2'd3
    } state_e;
endpackage

// File: rtl/wb_tracker.sv
// wb_tracker: in-flight register-write shift register with source match lookup.
module wb_tracker
    import cpu_pkg::*;
#(
    parameter int WB_LAT = WB_LAT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_v_i,
    input  logic [REG_W-1:0] push_rd_i,
    input  logic [REG_W-1:0] rs1_i,
    input  logic [REG_W-1:0] rs2_i,
    output logic             hit_a_o,
    output logic             hit_b_o,
    output logic             young_a_o,
    output logic             young_b_o,
    output logic             wb_v_o,
    output logic             any_v_o
);
    logic [WB_LAT-1:0] v_q;
    logic [REG_W-1:0]  rd_q [WB_LAT];

    // index 0 is the youngest slot; the last index writes the regfile this cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < WB_LAT; k++) begin
                v_q[k]  <= 1'b0;
                rd_q[k] <= '0;
            end
        end else begin
            v_q[0]  <= push_v_i;
            rd_q[0] <= push_rd_i;
            for (int k = 1; k < WB_LAT; k++) begin
                v_q[k]  <= v_q[k-1];
                rd_q[k] <= rd_q[k-1];
            end
        end
    end

    always_comb begin
        hit_a_o = 1'b0;
        hit_b_o = 1'b0;
        for (int k = 0; k < WB_LAT; k++) begin
            hit_a_o = hit_a_o | (v_q[k] && rd_q[k] == rs1_i);
            hit_b_o = hit_b_o | (v_q[k] && rd_q[k] == rs2_i);
        end
        young_a_o = v_q[0] && rd_q[0] == rs1_i;
        young_b_o = v_q[0] && rd_q[0] == rs2_i;
        wb_v_o    = v_q[WB_LAT-1];
        any_v_o   = |v_q;
    end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: issue/hazard/forwarding sequencer with halt/step/resume control
// and retire/stall counters.
module pipe_ctrl
    import cpu_pkg::*;
#(
    parameter int WB_LAT       = WB_LAT_DEF,
    parameter int FWD_EN       = 1,
    parameter int START_HALTED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid,
    input  logic [REG_W-1:0] dec_rs1,
    input  logic [REG_W-1:0] dec_rs2,
    input  logic             dec_use_rs2,
    input  logic             dec_we,
    input  logic [REG_W-1:0] dec_rdest,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic             resume_req,
    output logic             issue,
    output logic             bubble,
    output logic             fwd_a,
    output logic             fwd_b,
    output logic             halted,
    output logic [15:0]      retire_cnt,
    output logic [15:0]      stall_cnt
);
    state_e      state_q, state_d;
    logic        hit_a, hit_b, young_a, young_b, wb_v, any_v;
    logic        allow, hazard;
    logic [15:0] retire_q, stall_q;

    wb_tracker #(.WB_LAT(WB_LAT)) u_trk (
        .clk      (clk),
        .rst      (rst),
        .push_v_i (issue & dec_we),
        .push_rd_i(dec_rdest),
        .rs1_i    (dec_rs1),
        .rs2_i    (dec_rs2),
        .hit_a_o  (hit_a),
        .hit_b_o  (hit_b),
        .young_a_o(young_a),
        .young_b_o(young_b),
        .wb_v_o   (wb_v),
        .any_v_o  (any_v)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= (START_HALTED != 0) ? HALTED : RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q == RUN    ? (halt_req ? DRAIN : RUN) :
                  state_q == DRAIN  ? (any_v ? DRAIN : HALTED) :
                  state_q == HALTED ? (resume_req ? RUN : step_req ? STEP : HALTED) :
                                      (issue ? DRAIN : STEP);
    end

    // halt wins over issue in RUN; STEP ignores halt_req
    always_comb begin
        allow  = !rst && ((state_q == RUN && !halt_req) || state_q == STEP);
        fwd_a  = !rst && (FWD_EN != 0) && young_a;
        fwd_b  = !rst && (FWD_EN != 0) && dec_use_rs2 && young_b;
        hazard = (hit_a && !fwd_a) || (dec_use_rs2 && hit_b && !fwd_b);
        issue  = dec_valid && !hazard && allow;
        bubble = !issue;
        halted = state_q == HALTED;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retire_q <= '0;
            stall_q  <= '0;
        end else begin
            retire_q <= retire_q + {15'd0, wb_v};
            stall_q  <= stall_q + {15'd0, dec_valid && hazard && allow};
        end
    end

    assign retire_cnt = retire_q;
    assign stall_cnt  = stall_q;
endmodule
